// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: command decode, counters and strobe schedule
// for the matrix-vector multiply datapath (no data storage).
module mvm_seq_ctrl #(
    parameter int M    = 32,
    parameter int AW_A = $clog2(M*M),
    parameter int AW_X = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            loadMatrix,
    input  logic            loadVector,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW_A-1:0] a_addr,
    output logic            a_wr,
    output logic [AW_X-1:0] x_addr,
    output logic            x_wr,
    output logic            acc_en,
    output logic            acc_first,
    output logic            y_wr,
    output logic [AW_X-1:0] y_wr_addr,
    output logic            y_rd_en,
    output logic [AW_X-1:0] y_rd_addr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_A  = 3'd1;
    localparam logic [2:0] LOAD_X  = 3'd2;
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic [2:0] FLUSH   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] OUTPUT  = 3'd6;

    localparam logic [AW_A-1:0] LAST_A   = AW_A'(M*M-1);
    localparam logic [AW_A-1:0] LAST_X   = AW_A'(M-1);
    localparam logic [AW_A-1:0] ONE      = AW_A'(1);
    localparam logic [AW_X-1:0] LAST_COL = AW_X'(M-1);

    logic [2:0]      state;
    logic [AW_A-1:0] cnt;
    logic [AW_X-1:0] col;
    logic [AW_X-1:0] row;
    logic            rd_v;
    logic            rd_first;
    logic            rd_last;
    logic [AW_X-1:0] rd_row;
    logic            wr_v;
    logic [AW_X-1:0] wr_row;

    assign col = cnt[AW_X-1:0];
    assign row = cnt[AW_A-1:AW_X];

    // Two-stage pipe behind the read counter: memory latency, then MAC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_v     <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            rd_row   <= '0;
            wr_v     <= 1'b0;
            wr_row   <= '0;
        end else begin
            rd_v     <= (state == COMPUTE);
            rd_first <= (state == COMPUTE) && (col == '0);
            rd_last  <= (state == COMPUTE) && (col == LAST_COL);
            rd_row   <= row;
            wr_v     <= rd_last;
            wr_row   <= rd_row;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (loadMatrix)
                        state <= LOAD_A;
                    else if (loadVector)
                        state <= LOAD_X;
                    else if (start)
                        state <= COMPUTE;
                end
                LOAD_A, COMPUTE: begin
                    if (cnt == LAST_A) begin
                        state <= (state == COMPUTE) ? FLUSH : IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                LOAD_X, OUTPUT: begin
                    if (cnt == LAST_X) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                FLUSH: begin
                    if (cnt == ONE) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: begin
                    state <= OUTPUT;
                    cnt   <= ONE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign a_wr      = (state == LOAD_A);
    assign x_wr      = (state == LOAD_X);
    assign a_addr    = (a_wr || state == COMPUTE) ? cnt : '0;
    assign x_addr    = (x_wr || state == COMPUTE) ? col : '0;
    assign acc_en    = rd_v;
    assign acc_first = rd_first;
    assign y_wr      = wr_v;
    assign y_wr_addr = wr_v ? wr_row : '0;
    assign y_rd_en   = done || (state == OUTPUT);
    assign y_rd_addr = y_rd_en ? col : '0;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb_mvm_seq_ctrl: M=4 instance with a behavioural MVM datapath,
// plus an M=32 instance for the long load/compute timelines.
module tb_mvm_seq_ctrl;

    typedef struct packed {
        logic [15:0] busy, done, aw, xw, ae, af, yw, yr, aa, xa, ywa, yra;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b0, lm4 = 1'b0, lv4 = 1'b0, st4 = 1'b1;
    logic       busy4, done4, aw4, xw4, ae4, af4, yw4, yr4;
    logic [3:0] aa4;
    logic [1:0] xa4, ywa4, yra4;

    logic       rst32 = 1'b0, lm32 = 1'b0, lv32 = 1'b0, st32 = 1'b1;
    logic       busy32, done32, aw32, xw32, ae32, af32, yw32, yr32;
    logic [9:0] aa32;
    logic [4:0] xa32, ywa32, yra32;

    mvm_seq_ctrl #(.M(4)) dut (
        .clk(clk), .reset(rst4),
        .loadMatrix(lm4), .loadVector(lv4), .start(st4),
        .busy(busy4), .done(done4),
        .a_addr(aa4), .a_wr(aw4), .x_addr(xa4), .x_wr(xw4),
        .acc_en(ae4), .acc_first(af4),
        .y_wr(yw4), .y_wr_addr(ywa4),
        .y_rd_en(yr4), .y_rd_addr(yra4)
    );

    mvm_seq_ctrl #(.M(32)) dut32 (
        .clk(clk), .reset(rst32),
        .loadMatrix(lm32), .loadVector(lv32), .start(st32),
        .busy(busy32), .done(done32),
        .a_addr(aa32), .a_wr(aw32), .x_addr(xa32), .x_wr(xw32),
        .acc_en(ae32), .acc_first(af32),
        .y_wr(yw32), .y_wr_addr(ywa32),
        .y_rd_en(yr32), .y_rd_addr(yra32)
    );

    // Datapath around the M=4 controller: 1-cycle memories, MAC, Y buffer.
    logic signed [15:0] am [16];
    logic signed [15:0] xm [4];
    logic signed [15:0] ym [4];
    logic signed [15:0] aq, xq, acc, dout;
    logic signed [15:0] din = '0;

    always @(posedge clk) begin
        if (aw4) am[aa4] <= din;
        if (xw4) xm[xa4] <= din;
        aq <= am[aa4];
        xq <= xm[xa4];
        if (ae4) acc <= af4 ? 16'(aq * xq) : 16'(acc + aq * xq);
        if (yw4) ym[ywa4] <= acc;
        if (yr4) dout <= ym[yra4];
    end

    logic signed [15:0] ref_a [16];
    logic signed [15:0] ref_x [4];
    logic signed [15:0] nxt_a [16];
    logic signed [15:0] nxt_x [4];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [191:0] got,
                         input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected controls in cycle c after a command in cycle 0 (op 3 = none).
    function automatic ctl_t expc(int m, int op, int c);
        ctl_t e;
        int mm;
        e = '0;
        mm = m * m;
        if (op == 0 && c >= 1 && c <= mm) begin
            e.busy = 1; e.aw = 1; e.aa = 16'(c - 1);
        end
        if (op == 1 && c >= 1 && c <= m) begin
            e.busy = 1; e.xw = 1; e.xa = 16'(c - 1);
        end
        if (op == 2) begin
            if (c >= 1 && c <= mm + 2 + m) e.busy = 1;
            if (c >= 1 && c <= mm) begin
                e.aa = 16'(c - 1);
                e.xa = 16'((c - 1) % m);
            end
            if (c >= 2 && c <= mm + 1) begin
                e.ae = 1;
                e.af = 16'((c - 2) % m == 0);
            end
            if (c >= m + 2 && c <= mm + 2 && (c - 2) % m == 0) begin
                e.yw = 1;
                e.ywa = 16'((c - 2) / m - 1);
            end
            if (c == mm + 3) e.done = 1;
            if (c >= mm + 3 && c <= mm + 2 + m) begin
                e.yr = 1;
                e.yra = 16'(c - mm - 3);
            end
        end
        return e;
    endfunction

    function automatic ctl_t act(bit big);
        if (big)
            return {16'(busy32), 16'(done32), 16'(aw32), 16'(xw32),
                    16'(ae32), 16'(af32), 16'(yw32), 16'(yr32),
                    16'(aa32), 16'(xa32), 16'(ywa32), 16'(yra32)};
        return {16'(busy4), 16'(done4), 16'(aw4), 16'(xw4),
                16'(ae4), 16'(af4), 16'(yw4), 16'(yr4),
                16'(aa4), 16'(xa4), 16'(ywa4), 16'(yra4)};
    endfunction

    task automatic set_cmd(input bit big, input logic [2:0] cm);
        if (big) {lm32, lv32, st32} = cm;
        else {lm4, lv4, st4} = cm;
    endtask

    task automatic set_rst(input bit big, input logic v);
        if (big) rst32 = v;
        else rst4 = v;
    endtask

    task automatic idle_chk(input bit big, input string tag);
        check(tag, act(big), expc(4, 3, 0));
    endtask

    // Issue a command mask in the current cycle and check every cycle
    // through the first idle cycle afterwards (or a reset at rst_at).
    task automatic run_op(input bit big, input logic [2:0] cm,
                          input int rst_at, input int spur_at);
        int m, mm, op, len;
        int y [4];
        m = big ? 32 : 4;
        mm = m * m;
        op = cm[2] ? 0 : (cm[1] ? 1 : 2);
        len = (op == 0) ? mm : ((op == 1) ? m : mm + 2 + m);
        for (int j = 0; j < 4; j++) begin
            y[j] = 0;
            for (int k = 0; k < 4; k++)
                y[j] += int'(ref_a[j*4+k]) * int'(ref_x[k]);
        end
        set_cmd(big, cm);
        tick();
        set_cmd(big, 3'b000);
        for (int c = 1; c <= len + 1; c++) begin
            if (!big && op == 0 && c <= 16) begin
                din = nxt_a[c-1];
                ref_a[c-1] = nxt_a[c-1];
            end
            if (!big && op == 1 && c <= 4) begin
                din = nxt_x[c-1];
                ref_x[c-1] = nxt_x[c-1];
            end
            if (c == spur_at) set_cmd(big, 3'b001);
            if (c == spur_at + 1) set_cmd(big, 3'b000);
            check($sformatf("op%0d m%0d c%0d", op, m, c),
                  act(big), expc(m, op, c));
            if (!big && op == 2 && c >= mm + 4)
                check($sformatf("dout y%0d", c - mm - 4),
                      192'(dout), 192'(16'(y[c-mm-4])));
            if (c == rst_at) begin
                set_rst(big, 1'b0);
                set_cmd(big, 3'b001);
                tick();
                set_rst(big, 1'b1);
                set_cmd(big, 3'b000);
                check($sformatf("rst m%0d c%0d", m, c),
                      act(big), expc(m, 3, 0));
                return;
            end
            if (c <= len) tick();
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int ri, op, rst_at;
        logic [2:0] cm;
        bit rst_used;

        tick();
        idle_chk(0, "rst4 a");
        idle_chk(1, "rst32 a");
        tick();
        idle_chk(0, "rst4 b");
        idle_chk(1, "rst32 b");
        rst4 = 1'b1; rst32 = 1'b1; st4 = 1'b0; st32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_chk(0, "post rst4");
            idle_chk(1, "post rst32");
        end

        run_op(1, 3'b100, 0, 0);
        run_op(1, 3'b001, 500, 0);
        run_op(1, 3'b001, 0, 0);

        for (int i = 0; i < 16; i++)
            nxt_a[i] = (i % 5 == 0) ? 16'sd1 : 16'sd0;
        run_op(0, 3'b111, 0, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_chk(0, "no done");
        end
        nxt_x[0] = 16'sd1; nxt_x[1] = -16'sd2;
        nxt_x[2] = 16'sd3; nxt_x[3] = -16'sd4;
        run_op(0, 3'b010, 0, 0);
        run_op(0, 3'b001, 0, 0);

        rst_used = 1'b0;
        ri = $urandom_range(100, 900);
        for (int i = 0; i < 1000; i++) begin
            op = $urandom_range(0, 2);
            cm = (op == 0) ? (3'b100 | 3'($urandom_range(0, 3))) :
                 (op == 1) ? (3'b010 | 3'($urandom_range(0, 1))) : 3'b001;
            for (int k = 0; k < 16; k++)
                nxt_a[k] = 16'($signed($urandom_range(0, 6)) - 3);
            for (int k = 0; k < 4; k++)
                nxt_x[k] = 16'($signed($urandom_range(0, 14)) - 7);
            rst_at = 0;
            if (!rst_used && i >= ri && op == 2) begin
                rst_at = $urandom_range(1, 22);
                rst_used = 1'b1;
            end
            run_op(0, cm, rst_at, 0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                idle_chk(0, "gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Sequencing controller for the matrix-vector multiply datapath. It decodes the `loadMatrix` / `loadVector` / `start` command pulses and drives everything the datapath needs to run one command:
- write strobes and addresses for the matrix (A) and vector (X) memories;
- the read schedule and MAC enables for the row-by-row dot products;
- result (Y) buffer writes;
- the `done` pulse and the result read-out that places y[0..M-1] on `data_out` in the M cycles after `done`.

It holds no data and contains only the state machine and counters.

## Interface
Parameters:
- `M`, default 32: matrix dimension (A is M×M, X and Y are M). Must be a power of 2, at least 2.
- `AW_A`, default `$clog2(M*M)`: A address width.
- `AW_X`, default `$clog2(M)`: X/Y address width.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `loadMatrix`  in  1  one-cycle command: A words follow on the next M*M cycles
- `loadVector`  in  1  one-cycle command: X words follow on the next M cycles
- `start`  in  1  one-cycle command: compute Y = A·X
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse; y[0] is on `data_out` the next cycle
- `a_addr`  out  AW_A  A memory address (write in LOAD_A, read in COMPUTE)
- `a_wr`  out  1  A write enable
- `x_addr`  out  AW_X  X memory address
- `x_wr`  out  1  X write enable
- `acc_en`  out  1  MAC update enable
- `acc_first`  out  1  with `acc_en`: acc ← product instead of acc + product
- `y_wr`  out  1  Y buffer write enable; data is the accumulator register output
- `y_wr_addr`  out  AW_X  Y write row index
- `y_rd_en`  out  1  Y buffer read; registered `data_out` is valid the next cycle
- `y_rd_addr`  out  AW_X  Y read index

## Operation
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, FLUSH, DONE, OUTPUT.
- Commands are sampled only in IDLE.
  - Priority when several are high together: `loadMatrix` > `loadVector` > `start`. The losers are dropped.
  - Commands raised in any other state are ignored.
- **LOAD_A** (M*M cycles): `a_wr`=1; `a_addr` = word counter 0..M*M-1, row-major. The last word returns the FSM to IDLE.
- **LOAD_X** (M cycles): `x_wr`=1; `x_addr` = 0..M-1. The last word returns the FSM to IDLE.
- **COMPUTE** (M*M cycles): read counter n = 0..M*M-1.
  - `a_addr` = n; `x_addr` = n mod M (low AW_X bits).
  - Memories have 1-cycle read latency.
  - `acc_en` asserts one cycle after each read; `acc_first` is set on the one for n mod M = 0.
  - `y_wr` asserts two cycles after the last read of each row, with `y_wr_addr` = row.
  - Rows run back-to-back with no bubbles. A `y_wr` and the next row's `acc_first` update share a cycle; `y_wr` samples the pre-update register.
- **FLUSH** (2 cycles): drains the final `acc_en` and the final `y_wr`.
- **DONE** (1 cycle): `done`=1, `y_rd_en`=1, `y_rd_addr`=0.
- **OUTPUT** (M-1 cycles): `y_rd_en`=1; `y_rd_addr` = 1..M-1. Returns to IDLE.
- Any strobe not listed for a state is 0 in that state. Addresses are don't-care when their strobe is low; the bench must drive them to 0.
- `start` with never-loaded A or X is legal: the FSM sequences normally and the data is whatever the memories hold.

## Timing
- Reset: when `reset`=0 at an edge, the FSM goes to IDLE and all counters clear.
  - From the next cycle all outputs are 0: `busy`, `done`, every strobe, every address.
  - This holds from any state, including mid-load, mid-compute and mid-output.
  - Memory contents are not touched.
  - Commands high in the same cycle as `reset`=0 are discarded.
- Load latency: command in cycle 0; first `a_wr`/`x_wr` in cycle 1; last in cycle M*M (A) or M (X). IDLE in the following cycle, which can accept the next command.
- Compute timeline, `start` in cycle 0:
  - reads in cycles 1..M*M;
  - row r `y_wr` in cycle (r+1)·M + 2;
  - `done` in cycle M*M + 3 (cycle 1027 for M = 32);
  - `data_out` = y[j] in cycle M*M + 4 + j;
  - IDLE in cycle M*M + 3 + M, which can accept a command.
- `busy` is high from the cycle after an accepted command through the last active cycle.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `start`=1 -> all outputs 0. Release -> `busy` stays 0 and no `done` follows.
- **Load A (M=32):** `loadMatrix` in cycle 0 -> `a_wr`=1 for exactly cycles 1..1024 with `a_addr`=cycle-1. `busy` falls at cycle 1025.
- **Compute (M=4):** `start` in cycle 0 ->
  - `acc_first` in cycles 2, 6, 10, 14;
  - `y_wr` rows 0..3 in cycles 6, 10, 14, 18;
  - `done` in cycle 19; `y_rd_addr` 0..3 in cycles 19..22;
  - a behavioral memory+MAC model gives A=I, X=[1,-2,3,-4] -> `data_out` = 1, -2, 3, -4.
- **Command priority:** `loadMatrix`=`loadVector`=`start`=1 in IDLE -> LOAD_A only. A `start` pulse during LOAD_A is ignored: no `done` ever appears.
- **Mid-compute reset (M=32):** `reset`=0 in cycle 500 after `start` -> next cycle all strobes 0. A new `start` yields `done` exactly 1027 cycles later.
- **Random regression:** 1000 random `loadMatrix`/`loadVector`/`start` operations through the full MVM, including one random mid-run reset. Values are bounded so the 16-bit sum cannot overflow. Every y[j] must match the software dot product.
